vga_box_renderer: RTL and testbench

- Pixel-generation stage directly downstream of the VGA timing controller (800x600 active, 1040x666 total).
- Consumes the controller's nextX/nextY, blank and sync strobes; produces 24-bit RGB plus sync/blank outputs delayed to match the pipeline.
- Draws a solid box that moves once per frame and bounces off the screen edges, over a background.

---
 rtl/vga_box_renderer_pkg.sv | 21 ++
 rtl/vga_box_renderer_if.sv | 28 ++
 rtl/vga_box_renderer_box_motion.sv | 95 +++++++++
 rtl/vga_box_renderer.sv | 120 ++++++++++++
 tb/tb_vga_box_renderer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/vga_box_renderer_pkg.sv
// Shared VGA timing constants, pixel colour struct and box direction type
// used by the renderer and its motion sub-block.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;
    localparam int H_TOTAL      = 1040;
    localparam int V_TOTAL      = 666;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        DIR_POS,
        DIR_NEG
    } dir_t;

endpackage

// File: rtl/vga_box_renderer_if.sv
// Pixel bus between the VGA timing controller and the box renderer.
// master = timing-controller / display side, slave = renderer.
interface vga_box_renderer_if;
    logic [10:0] nextX;
    logic [9:0]  nextY;
    logic        blank_n_in;
    logic        hSync_n_in;
    logic        vSync_n_in;
    logic        sync_n_in;
    logic        Freeze;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        blank_n;
    logic        sync_n;
    logic        hSync_n;
    logic        vSync_n;

    modport master (
        output nextX, nextY, blank_n_in, hSync_n_in, vSync_n_in, sync_n_in, Freeze,
        input  red, green, blue, blank_n, sync_n, hSync_n, vSync_n
    );

    modport slave (
        input  nextX, nextY, blank_n_in, hSync_n_in, vSync_n_in, sync_n_in, Freeze,
        output red, green, blue, blank_n, sync_n, hSync_n, vSync_n
    );
endinterface

// File: rtl/vga_box_renderer_box_motion.sv
// Box position state: detects the vSync falling edge (once per frame, inside
// vertical blank) and steps the box, bouncing off the active-area edges.
module box_motion
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_W    = 64,
    parameter int BOX_H    = 48,
    parameter int SPEED    = 4,
    parameter int INIT_X   = 100,
    parameter int INIT_Y   = 50
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        vsync_n_i,
    input  logic        freeze_i,
    output logic [11:0] box_x_o,
    output logic [11:0] box_y_o
);

    localparam logic [11:0] X_MAX   = 12'(H_ACTIVE - BOX_W);
    localparam logic [11:0] Y_MAX   = 12'(V_ACTIVE - BOX_H);
    localparam logic [11:0] SPEED_V = 12'(SPEED);

    logic        vs_prev_q;
    logic [11:0] box_x_q, box_x_d;
    logic [11:0] box_y_q, box_y_d;
    dir_t        dir_x_q, dir_x_d;
    dir_t        dir_y_q, dir_y_d;
    logic        tick;

    assign tick = ~vsync_n_i & vs_prev_q;

    // Next position/direction: both axes step together on an unfrozen tick.
    always_comb begin
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (tick && !freeze_i) begin
            if (dir_x_q == DIR_POS) begin
                if (box_x_q + SPEED_V >= X_MAX) begin
                    box_x_d = X_MAX;
                    dir_x_d = DIR_NEG;
                end else begin
                    box_x_d = box_x_q + SPEED_V;
                end
            end else begin
                if (box_x_q <= SPEED_V) begin
                    box_x_d = '0;
                    dir_x_d = DIR_POS;
                end else begin
                    box_x_d = box_x_q - SPEED_V;
                end
            end
            if (dir_y_q == DIR_POS) begin
                if (box_y_q + SPEED_V >= Y_MAX) begin
                    box_y_d = Y_MAX;
                    dir_y_d = DIR_NEG;
                end else begin
                    box_y_d = box_y_q + SPEED_V;
                end
            end else begin
                if (box_y_q <= SPEED_V) begin
                    box_y_d = '0;
                    dir_y_d = DIR_POS;
                end else begin
                    box_y_d = box_y_q - SPEED_V;
                end
            end
        end
    end

    // Position, direction and previous-vSync registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vs_prev_q <= 1'b1;
            box_x_q   <= 12'(INIT_X);
            box_y_q   <= 12'(INIT_Y);
            dir_x_q   <= DIR_POS;
            dir_y_q   <= DIR_POS;
        end else begin
            vs_prev_q <= vsync_n_i;
            box_x_q   <= box_x_d;
            box_y_q   <= box_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
        end
    end

    assign box_x_o = box_x_q;
    assign box_y_o = box_y_q;

endmodule

// File: rtl/vga_box_renderer.sv
// Two-stage pixel pipeline drawing a bouncing solid box over a background.
// Optional feature macro: VGA_BOX_CHECKER_EN (32x32 checkerboard background).
module vga_box_renderer
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_DEF,
    parameter int          V_ACTIVE = V_ACTIVE_DEF,
    parameter int          BOX_W    = 64,
    parameter int          BOX_H    = 48,
    parameter int          SPEED    = 4,
    parameter int          INIT_X   = 100,
    parameter int          INIT_Y   = 50,
    parameter logic [23:0] BOX_RGB  = 24'hFF0000,
    parameter logic [23:0] BG_RGB   = 24'h000040
) (
    input  logic               Clock,
    input  logic               Reset,
    vga_box_renderer_if.slave  bus
);

    localparam logic [11:0] BOX_W_V = 12'(BOX_W);
    localparam logic [11:0] BOX_H_V = 12'(BOX_H);

    logic [11:0] box_x, box_y;
    logic [11:0] px, py;
    logic        in_box_d, in_box_q;
    logic        blank_s1_q, hs_s1_q, vs_s1_q, sy_s1_q;
    rgb_t        rgb_d, rgb_q;
    rgb_t        bg;
    logic        blank_q, hs_q, vs_q, sy_q;

    box_motion #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_W    (BOX_W),
        .BOX_H    (BOX_H),
        .SPEED    (SPEED),
        .INIT_X   (INIT_X),
        .INIT_Y   (INIT_Y)
    ) u_motion (
        .Clock     (Clock),
        .Reset     (Reset),
        .vsync_n_i (bus.vSync_n_in),
        .freeze_i  (bus.Freeze),
        .box_x_o   (box_x),
        .box_y_o   (box_y)
    );

    assign px = {1'b0, bus.nextX};
    assign py = {2'b00, bus.nextY};

    // Stage-1 hit test against the current box rectangle.
    always_comb begin
        in_box_d = (px >= box_x) && (px < box_x + BOX_W_V) &&
                   (py >= box_y) && (py < box_y + BOX_H_V);
    end

`ifdef VGA_BOX_CHECKER_EN
    logic chk_s1_q;

    // Checker square select captured alongside the hit test.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) chk_s1_q <= 1'b0;
        else       chk_s1_q <= bus.nextX[5] ^ bus.nextY[5];
    end

    assign bg = chk_s1_q ? ~BG_RGB : BG_RGB;
`else
    assign bg = BG_RGB;
`endif

    // Stage-2 colour: blanking wins, then box, then background.
    always_comb begin
        rgb_d = '0;
        if (blank_s1_q) rgb_d = in_box_q ? rgb_t'(BOX_RGB) : bg;
    end

    // Stage 1: hit flag and strobes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            in_box_q   <= 1'b0;
            blank_s1_q <= 1'b0;
            hs_s1_q    <= 1'b1;
            vs_s1_q    <= 1'b1;
            sy_s1_q    <= 1'b1;
        end else begin
            in_box_q   <= in_box_d;
            blank_s1_q <= bus.blank_n_in;
            hs_s1_q    <= bus.hSync_n_in;
            vs_s1_q    <= bus.vSync_n_in;
            sy_s1_q    <= bus.sync_n_in;
        end
    end

    // Stage 2: colour and strobes aligned with it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rgb_q   <= '0;
            blank_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            sy_q    <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            blank_q <= blank_s1_q;
            hs_q    <= hs_s1_q;
            vs_q    <= vs_s1_q;
            sy_q    <= sy_s1_q;
        end
    end

    assign bus.red     = rgb_q.r;
    assign bus.green   = rgb_q.g;
    assign bus.blue    = rgb_q.b;
    assign bus.blank_n = blank_q;
    assign bus.hSync_n = hs_q;
    assign bus.vSync_n = vs_q;
    assign bus.sync_n  = sy_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Randomized bench for vga_box_renderer against a frame-level box model.
module tb_vga_box_renderer;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int BOX_W    = 64;
    localparam int BOX_H    = 48;
    localparam int SPEED    = 4;
    localparam int INIT_X   = 100;
    localparam int INIT_Y   = 50;
    localparam logic [23:0] BOX_C = 24'hFF0000;
    localparam logic [23:0] BG_C  = 24'h000040;

    typedef struct {
        logic [23:0] rgb;
        logic        bl;
        logic [2:0]  syncs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    int   mbx, mby, mdx, mdy;
    bit   mvs_prev;
    exp_t q[$];

    vga_box_renderer_if vif ();

    vga_box_renderer dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mbx = INIT_X; mby = INIT_Y; mdx = 1; mdy = 1; mvs_prev = 1'b1;
    endfunction

    // One frame of motion along an axis of length lim.
    function automatic void move(inout int pos, inout int dir, input int lim);
        if (dir > 0) begin
            if (pos + SPEED >= lim) begin pos = lim; dir = -1; end
            else pos = pos + SPEED;
        end else begin
            if (pos <= SPEED) begin pos = 0; dir = 1; end
            else pos = pos - SPEED;
        end
    endfunction

    function automatic logic [23:0] pixel_colour(input int x, input int y, input bit bl);
        logic [23:0] bg;
        bg = BG_C;
`ifdef VGA_BOX_CHECKER_EN
        if ((((x / 32) ^ (y / 32)) & 1) == 1) bg = ~BG_C;
`endif
        if (!bl) return 24'h0;
        if (x >= mbx && x < mbx + BOX_W && y >= mby && y < mby + BOX_H) return BOX_C;
        return bg;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_rgb"},   {vif.red, vif.green, vif.blue}, e.rgb);
        check({tag, "_blank"}, vif.blank_n, e.bl);
        check({tag, "_syncs"}, {vif.hSync_n, vif.vSync_n, vif.sync_n}, e.syncs);
    endtask

    // One pixel clock: check the result due now, then present new inputs.
    task automatic step(input int x, input int y, input bit bl, input bit vs, input bit fr);
        exp_t e;
        bit   hs, sy;
        @(negedge clk);
        if (q.size() == 2) check_outputs("pix", q.pop_front());
        hs = 1'($urandom_range(0, 1));
        sy = 1'($urandom_range(0, 1));
        vif.nextX      = 11'(x);
        vif.nextY      = 10'(y);
        vif.blank_n_in = bl;
        vif.hSync_n_in = hs;
        vif.vSync_n_in = vs;
        vif.sync_n_in  = sy;
        vif.Freeze     = fr;
        e.rgb   = pixel_colour(x, y, bl);
        e.bl    = bl;
        e.syncs = {hs, vs, sy};
        q.push_back(e);
        if (!vs && mvs_prev && !fr) begin
            move(mbx, mdx, H_ACTIVE - BOX_W);
            move(mby, mdy, V_ACTIVE - BOX_H);
        end
        mvs_prev = vs;
    endtask

    // Random probe biased toward the box edges.
    task automatic probe(input bit vs);
        int x, y;
        bit bl;
        if ($urandom_range(0, 1) == 1) begin
            x = mbx + int'($urandom_range(0, BOX_W + 3)) - 2;
            y = mby + int'($urandom_range(0, BOX_H + 3)) - 2;
            if (x < 0) x = 0;
            if (y < 0) y = 0;
        end else begin
            x = int'($urandom_range(0, 1039));
            y = int'($urandom_range(0, 665));
        end
        bl = ($urandom_range(0, 4) != 0);
        step(x, y, bl, vs, 1'b0);
    endtask

    task automatic frame_tick(input bit fr);
        step(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)), 1'b0, 1'b0, fr);
        step(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)), 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t e;
        e.rgb = 24'h0; e.bl = 1'b0; e.syncs = 3'b111;
        check_outputs(tag, e);
    endtask

    initial begin
        vif.nextX = '0; vif.nextY = '0; vif.blank_n_in = 1'b0;
        vif.hSync_n_in = 1'b0; vif.vSync_n_in = 1'b1; vif.sync_n_in = 1'b0;
        vif.Freeze = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // First visible pixel and the box-edge pixels at the initial position.
        step(0, 0, 1'b1, 1'b1, 1'b0);
        step(100, 50, 1'b1, 1'b1, 1'b0);
        step(163, 97, 1'b1, 1'b1, 1'b0);
        step(164, 50, 1'b1, 1'b1, 1'b0);
        step(32, 0, 1'b1, 1'b1, 1'b0);
        step(32, 32, 1'b1, 1'b1, 1'b0);

        // One tick moves the box; a long low vSync must not move it again.
        frame_tick(1'b0);
        step(104, 54, 1'b1, 1'b1, 1'b0);
        step(103, 54, 1'b1, 1'b1, 1'b0);
        step(104, 53, 1'b1, 1'b1, 1'b0);
        step(167, 101, 1'b1, 1'b1, 1'b0);
        step(168, 101, 1'b1, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (6240) probe(1'b0);
        repeat (4) probe(1'b1);

        // Frozen ticks hold the position.
        repeat (3) frame_tick(1'b1);
        repeat (20) probe(1'b1);

        // Long random run: enough ticks to bounce on all four edges.
        for (int it = 0; it < 90; it++) begin
            int nt;
            nt = int'($urandom_range(0, 12));
            for (int t = 0; t < nt; t++) frame_tick($urandom_range(0, 3) == 0);
            repeat (16) probe(1'b1);
        end

        // Asynchronous reset mid-frame.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(100, 50, 1'b1, 1'b1, 1'b0);
        step(99, 50, 1'b1, 1'b1, 1'b0);
        frame_tick(1'b0);
        step(104, 54, 1'b1, 1'b1, 1'b0);
        step(103, 54, 1'b1, 1'b1, 1'b0);
        repeat (40) probe(1'b1);

        // Drain the pipeline.
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
